serial_mag_compare_ctrl: RTL and testbench

// Sequential magnitude comparator controller. Compares two WIDTH-bit operands
// by stepping one shared comp_2 slice (2-bit cascaded eq/gt cell) from MSB

---
 rtl/serial_mag_compare_ctrl_pkg.sv | 13 +
 rtl/serial_mag_compare_ctrl_comp_2.sv | 22 ++
 rtl/serial_mag_compare_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared state encodings and chain-seed constants for the serial magnitude comparator.
package serial_mag_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic EQ_SEED = 1'b1;
  localparam logic GT_SEED = 1'b0;

endpackage

// File: rtl/serial_mag_compare_ctrl_comp_2.sv
// 2-bit cascaded compare cell: folds one operand pair into the running eq/gt chain.
module comp_2 (
  input  logic       eq_i,
  input  logic       gt_i,
  input  logic [1:0] in1_i,
  input  logic [1:0] in2_i,
  output logic       eq_o,
  output logic       gt_o
);

  logic pair_eq;
  logic pair_gt;

  assign pair_eq = (in1_i == in2_i);
  assign pair_gt = (in1_i[1] & ~in2_i[1]) |
                   (~(in1_i[1] ^ in2_i[1]) & in1_i[0] & ~in2_i[0]);

  // A higher pair that already decided the result masks every lower pair.
  assign eq_o = eq_i & pair_eq;
  assign gt_o = gt_i | (eq_i & pair_gt);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator: walks one shared comp_2 cell from the MSB pair down.
module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_cmp_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  localparam int NPAIR = WIDTH / 2;
  localparam int IW    = ($clog2(NPAIR) > 1) ? $clog2(NPAIR) : 1;
  localparam logic [IW-1:0]    IDX_TOP = IW'(NPAIR - 1);
  localparam logic [WIDTH-1:0] MSB     = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_acc_q, eq_acc_d, gt_acc_q, gt_acc_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [1:0]       pair_a, pair_b;
  logic             c_eq, c_gt;

  always_comb begin
    pair_a = '0;
    pair_b = '0;
    for (int p = 0; p < NPAIR; p++) begin
      if (idx_q == IW'(p)) begin
        pair_a = op_a_q[2*p +: 2];
        pair_b = op_b_q[2*p +: 2];
      end
    end
  end

  comp_2 u_comp_2 (
    .eq_i  (eq_acc_q),
    .gt_i  (gt_acc_q),
    .in1_i (pair_a),
    .in2_i (pair_b),
    .eq_o  (c_eq),
    .gt_o  (c_gt)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    idx_d    = idx_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          op_a_d   = signed_cmp_i ? (a_i ^ MSB) : a_i;
          op_b_d   = signed_cmp_i ? (b_i ^ MSB) : b_i;
          eq_acc_d = EQ_SEED;
          gt_acc_d = GT_SEED;
          idx_d    = IDX_TOP;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        eq_acc_d = c_eq;
        gt_acc_d = c_gt;
        idx_d    = idx_q - 1'b1;
        if (idx_q == '0 || (EARLY_EXIT && !c_eq)) begin
          // Results are loaded as DONE is entered so they are valid alongside done_o.
          eq_d    = c_eq;
          gt_d    = c_gt;
          lt_d    = ~c_eq & ~c_gt;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      idx_q    <= '0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      idx_q    <= idx_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign eq_o   = eq_q;
  assign gt_o   = gt_q;
  assign lt_o   = lt_q;

  a_chain_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    !(eq_acc_q && gt_acc_q));

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench: three comparator instances checked cycle by cycle against an arithmetic model.
module tb_serial_mag_compare_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st[3], sg[3];
  logic [31:0] a_s[3], b_s[3];
  logic        busy[3], done[3], eq[3], gt[3], lt[3];
  logic [2:0]  prev[3];
  int checks = 0;
  int errors = 0;

  // d0: WIDTH=32 no early exit; d1: WIDTH=32 early exit; d2: WIDTH=2
  serial_mag_compare_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_d0 (
    .clk_i(clk), .reset_i(rst), .start_i(st[0]), .signed_cmp_i(sg[0]),
    .a_i(a_s[0]), .b_i(b_s[0]), .busy_o(busy[0]), .done_o(done[0]),
    .eq_o(eq[0]), .gt_o(gt[0]), .lt_o(lt[0]));
  serial_mag_compare_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_d1 (
    .clk_i(clk), .reset_i(rst), .start_i(st[1]), .signed_cmp_i(sg[1]),
    .a_i(a_s[1]), .b_i(b_s[1]), .busy_o(busy[1]), .done_o(done[1]),
    .eq_o(eq[1]), .gt_o(gt[1]), .lt_o(lt[1]));
  serial_mag_compare_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) u_d2 (
    .clk_i(clk), .reset_i(rst), .start_i(st[2]), .signed_cmp_i(sg[2]),
    .a_i(a_s[2][1:0]), .b_i(b_s[2][1:0]), .busy_o(busy[2]), .done_o(done[2]),
    .eq_o(eq[2]), .gt_o(gt[2]), .lt_o(lt[2]));

  // {eq,gt,lt} from plain integer comparison of the w-bit operands
  function automatic logic [2:0] model_res(logic [31:0] a, logic [31:0] b, logic s, int w);
    longint m, va, vb;
    m  = (longint'(1) << w) - 1;
    va = longint'(a) & m;
    vb = longint'(b) & m;
    if (s) begin
      if (va >= (longint'(1) << (w-1))) va = va - (longint'(1) << w);
      if (vb >= (longint'(1) << (w-1))) vb = vb - (longint'(1) << w);
    end
    if (va == vb) return 3'b100;
    else if (va > vb) return 3'b010;
    else return 3'b001;
  endfunction

  // done cycle: one past the cycle that examines the deciding pair
  function automatic int model_cyc(logic [31:0] a, logic [31:0] b, int w, bit ee);
    logic [31:0] x;
    x = a ^ b;
    if (ee) begin
      for (int p = w/2 - 1; p >= 0; p--)
        if (((x >> (2*p)) & 32'd3) != 0) return w/2 - p + 1;
    end
    return w/2 + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int res_of(int d);
    return {eq[d], gt[d], lt[d]};
  endfunction

  task automatic run_cmp(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int lit_res, input int lit_cyc, input bit poke);
    int w, ec, cyc;
    logic [2:0] er;
    w  = (d == 2) ? 2 : 32;
    er = model_res(a, b, s, w);
    ec = model_cyc(a, b, w, d != 0);
    @(negedge clk);
    st[d] = 1'b1; a_s[d] = a; b_s[d] = b; sg[d] = s;
    @(posedge clk); #1;
    cyc = 1;
    while (1) begin
      chk($sformatf("d%0d busy c%0d", d, cyc), busy[d], 1);
      chk($sformatf("d%0d done c%0d", d, cyc), done[d], (cyc == ec) ? 1 : 0);
      if (lit_cyc >= 0)
        chk($sformatf("d%0d lit_done c%0d", d, cyc), done[d], (cyc == lit_cyc) ? 1 : 0);
      chk($sformatf("d%0d res c%0d", d, cyc), res_of(d), (cyc >= ec) ? er : prev[d]);
      if (cyc >= ec) break;
      @(negedge clk);
      // operands are free to move once sampled; an optional stray start lands in RUN
      st[d]  = (poke && cyc == 1);
      a_s[d] = poke ? ~a : $urandom;
      b_s[d] = poke ? a : $urandom;
      sg[d]  = poke ? ~s : s;
      @(posedge clk); #1;
      cyc++;
    end
    if (lit_res >= 0) chk($sformatf("d%0d lit_res", d), res_of(d), lit_res);
    prev[d] = er;
    @(negedge clk);
    st[d] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("d%0d idle busy", d), busy[d], 0);
    chk($sformatf("d%0d idle done", d), done[d], 0);
    chk($sformatf("d%0d hold res", d), res_of(d), prev[d]);
  endtask

  task automatic check_all_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d busy", tag, d), busy[d], 0);
      chk($sformatf("%s d%0d done", tag, d), done[d], 0);
      chk($sformatf("%s d%0d res", tag, d), res_of(d), 0);
      prev[d] = 3'b000;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; sg[d] = 1'b0; a_s[d] = '0; b_s[d] = '0; prev[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 check_all_reset("reset");
    @(negedge clk) rst = 1'b0;

    // unsigned, full-length walk
    run_cmp(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 3'b010, 17, 1'b0);
    run_cmp(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b100, 17, 1'b0);
    // signed vs unsigned interpretation of the same bits
    run_cmp(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 17, 1'b0);
    run_cmp(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b010, 17, 1'b0);
    // stray start during RUN, then back-to-back start right after done
    run_cmp(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 3'b001, 17, 1'b1);
    run_cmp(0, 32'h0000_0002, 32'h0000_0001, 1'b0, 3'b010, 17, 1'b0);

    // early exit
    run_cmp(1, 32'h8000_0000, 32'h0000_0000, 1'b0, 3'b010, 2, 1'b0);
    run_cmp(1, 32'h0000_1234, 32'h0000_1234, 1'b0, 3'b100, 17, 1'b0);
    run_cmp(1, 32'h0000_0000, 32'h8000_0000, 1'b1, 3'b010, 2, 1'b0);
    run_cmp(1, 32'h0040_0000, 32'h0080_0000, 1'b0, 3'b001, 6, 1'b0);
    run_cmp(1, 32'h0000_0003, 32'h0000_0000, 1'b0, 3'b010, 17, 1'b0);
    run_cmp(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'b010, 2, 1'b0);

    // WIDTH=2: literal pin, then every operand pair in both modes
    run_cmp(2, 32'd2, 32'd1, 1'b1, 3'b001, 2, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          run_cmp(2, 32'(a), 32'(b), s[0], -1, 2, 1'b0);

    // reset in the middle of a compare: no done, everything cleared
    @(negedge clk);
    st[0] = 1'b1; a_s[0] = 32'h1; b_s[0] = 32'h2; sg[0] = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("abort busy c%0d", c), busy[0], 1);
      chk($sformatf("abort done c%0d", c), done[0], 0);
      @(negedge clk);
      st[0] = 1'b0;
      if (c == 5) rst = 1'b1;
      @(posedge clk); #1;
    end
    check_all_reset("abort");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("abort stays idle", busy[0], 0);

    // reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1; st[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_vs_start busy", busy[0], 0);
    @(negedge clk);
    rst = 1'b0; st[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_start idle", busy[0], 0);

    // results still correct after the aborted compare
    run_cmp(0, 32'h1234_5678, 32'h1234_5679, 1'b0, 3'b001, 17, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
